// File: rtl/ram_arbiter.sv
// Two-port arbiter serialising CPU and loader byte/word transactions into
// single-byte RAM beats, big-endian, with round-robin tie breaking.
module ram_arbiter #(
  parameter int ADDR_W = 9
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic              cpu_size,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_mfc,
  input  logic              ldr_req,
  input  logic              ldr_rw,
  input  logic              ldr_size,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [31:0]       ldr_wdata,
  output logic [31:0]       ldr_rdata,
  output logic              ldr_mfc,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_XFER    = 2'd1;
  localparam logic [1:0] S_RD_TAIL = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        r_beat;
  logic              r_last_cpu;
  logic              r_own_cpu;
  logic              r_rw;
  logic              r_size;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_wdata;
  logic [23:0]       r_asm;

  logic              r_ram_en, r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_wdata;
  logic [31:0]       r_cpu_rdata, r_ldr_rdata;
  logic              r_cpu_mfc, r_ldr_mfc;
  logic [1:0]        r_grant;
  logic              r_busy;

  logic              w_pick_cpu;
  logic              w_rw, w_size;
  logic [ADDR_W-1:0] w_addr, w_base;
  logic [31:0]       w_wdata;
  logic [1:0]        w_next_beat;
  logic              w_last_beat;

  function automatic logic [7:0] wbyte(input logic [31:0] d, input logic sz,
                                       input logic [1:0] b);
    if (!sz) return d[7:0];
    case (b)
      2'd0:    return d[31:24];
      2'd1:    return d[23:16];
      2'd2:    return d[15:8];
      default: return d[7:0];
    endcase
  endfunction

  // On a tie the side that did not win last time takes the RAM.
  always_comb begin
    w_pick_cpu  = cpu_req & (~ldr_req | ~r_last_cpu);
    w_rw        = w_pick_cpu ? cpu_rw    : ldr_rw;
    w_size      = w_pick_cpu ? cpu_size  : ldr_size;
    w_addr      = w_pick_cpu ? cpu_addr  : ldr_addr;
    w_wdata     = w_pick_cpu ? cpu_wdata : ldr_wdata;
    w_base      = w_size ? {w_addr[ADDR_W-1:2], 2'b00} : w_addr;
    w_next_beat = r_beat + 2'd1;
    w_last_beat = r_size ? (r_beat == 2'd3) : 1'b1;
  end

  always_ff @(posedge main_clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_beat      <= 2'd0;
      r_last_cpu  <= 1'b0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= 8'h00;
      r_cpu_rdata <= 32'h0;
      r_ldr_rdata <= 32'h0;
      r_cpu_mfc   <= 1'b0;
      r_ldr_mfc   <= 1'b0;
      r_grant     <= 2'b00;
      r_busy      <= 1'b0;
    end else begin
      r_cpu_mfc <= 1'b0;
      r_ldr_mfc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cpu_req || ldr_req) begin
            r_own_cpu   <= w_pick_cpu;
            r_last_cpu  <= w_pick_cpu;
            r_rw        <= w_rw;
            r_size      <= w_size;
            r_base      <= w_base;
            r_wdata     <= w_wdata;
            r_beat      <= 2'd0;
            r_asm       <= 24'h0;
            r_ram_en    <= 1'b1;
            r_ram_we    <= ~w_rw;
            r_ram_addr  <= w_base;
            r_ram_wdata <= wbyte(w_wdata, w_size, 2'd0);
            r_grant     <= w_pick_cpu ? 2'b10 : 2'b01;
            r_busy      <= 1'b1;
            r_state     <= S_XFER;
          end
        end
        S_XFER: begin
          // Read data lags its issue by one cycle, so beat N captures byte N-1.
          if (r_rw && r_beat != 2'd0) r_asm <= {r_asm[15:0], ram_rdata};
          if (w_last_beat) begin
            r_ram_en <= 1'b0;
            r_ram_we <= 1'b0;
            if (r_rw) begin
              r_state <= S_RD_TAIL;
            end else begin
              r_state   <= S_DONE;
              r_cpu_mfc <= r_own_cpu;
              r_ldr_mfc <= ~r_own_cpu;
            end
          end else begin
            r_beat      <= w_next_beat;
            r_ram_addr  <= r_base + ADDR_W'(w_next_beat);
            r_ram_wdata <= wbyte(r_wdata, r_size, w_next_beat);
          end
        end
        S_RD_TAIL: begin
          if (r_own_cpu) r_cpu_rdata <= {r_asm, ram_rdata};
          else           r_ldr_rdata <= {r_asm, ram_rdata};
          r_cpu_mfc <= r_own_cpu;
          r_ldr_mfc <= ~r_own_cpu;
          r_state   <= S_DONE;
        end
        default: begin
          r_grant <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata = r_cpu_rdata;
  assign ldr_rdata = r_ldr_rdata;
  assign cpu_mfc   = r_cpu_mfc;
  assign ldr_mfc   = r_ldr_mfc;
  assign grant     = r_grant;
  assign busy      = r_busy;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 512-byte synchronous RAM.
module tb_ram_arbiter;

  logic        main_clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_rw, cpu_size;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_mfc;
  logic        ldr_req, ldr_rw, ldr_size;
  logic [8:0]  ldr_addr;
  logic [31:0] ldr_wdata, ldr_rdata;
  logic        ldr_mfc;
  logic [1:0]  grant;
  logic        busy, ram_en, ram_we;
  logic [8:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;

  logic [7:0]  mem [0:511] = '{default: 8'h00};

  int n_cmp = 0;
  int n_err = 0;

  always #5 main_clk = ~main_clk;

  always @(posedge main_clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  ram_arbiter #(.ADDR_W(9)) dut (
    .main_clk(main_clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_mfc(cpu_mfc),
    .ldr_req(ldr_req), .ldr_rw(ldr_rw), .ldr_size(ldr_size), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata), .ldr_mfc(ldr_mfc),
    .grant(grant), .busy(busy), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  task automatic tick();
    @(posedge main_clk);
    @(negedge main_clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one transaction from one side, wait (bounded) for its mfc, then
  // release req and spend the mandatory IDLE cycle.
  task automatic xact(input bit is_cpu, input bit rw, input bit size,
                      input logic [8:0] addr, input logic [31:0] wd,
                      output int lat, output int beats,
                      output logic [8:0] a_first, output logic [8:0] a_last,
                      output bit we_seen);
    if (is_cpu) begin
      cpu_rw = rw; cpu_size = size; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    end else begin
      ldr_rw = rw; ldr_size = size; ldr_addr = addr; ldr_wdata = wd; ldr_req = 1'b1;
    end
    lat = -1; beats = 0; we_seen = 1'b0; a_first = 9'h0; a_last = 9'h0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (ram_en) begin
        if (beats == 0) a_first = ram_addr;
        a_last = ram_addr;
        beats++;
      end
      if (ram_we) we_seen = 1'b1;
      if (is_cpu ? cpu_mfc : ldr_mfc) begin
        lat = c;
        break;
      end
    end
    cpu_req = 1'b0;
    ldr_req = 1'b0;
    tick();
  endtask

  int          lat, beats, c_done;
  logic [8:0]  a_first, a_last;
  bit          we_seen;
  int          cpu_cnt, ldr_cnt, n_mfc, bad_gap, prev_c;
  logic [7:0]  order;

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_rw = 0; cpu_size = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_rw = 0; ldr_size = 0; ldr_addr = 0; ldr_wdata = 0;
    tick();
    tick();
    chk("reset_ctrl", 64'({ram_en, ram_we, ram_addr, ram_wdata, cpu_mfc, ldr_mfc, grant, busy}), 64'h0);
    chk("reset_rdata", {cpu_rdata, ldr_rdata}, 64'h0);
    reset = 1'b0;
    tick();

    // Loader word write then read back
    xact(1'b0, 1'b0, 1'b1, 9'd8, 32'hE3A01005, lat, beats, a_first, a_last, we_seen);
    chk("t1_wr_lat", 64'(lat), 64'd5);
    chk("t1_wr_beats", 64'(beats), 64'd4);
    chk("t1_wr_addr", {39'h0, a_first, 7'h0, a_last}, {39'h0, 9'd8, 7'h0, 9'd11});
    chk("t1_mem", 64'({mem[8], mem[9], mem[10], mem[11]}), 64'hE3A01005);
    xact(1'b0, 1'b1, 1'b1, 9'd8, 32'h0, lat, beats, a_first, a_last, we_seen);
    chk("t1_rd_lat", 64'(lat), 64'd6);
    chk("t1_rd_data", 64'(ldr_rdata), 64'hE3A01005);
    chk("t1_cpu_rdata", 64'(cpu_rdata), 64'h0);
    chk("t1_rd_no_we", 64'(we_seen), 64'd0);

    // Seed word @0 for the tie test
    xact(1'b0, 1'b0, 1'b1, 9'd0, 32'hCAFEF00D, lat, beats, a_first, a_last, we_seen);
    chk("t2_seed_lat", 64'(lat), 64'd5);

    // Simultaneous requests: CPU wins the first tie
    cpu_rw = 1; cpu_size = 1; cpu_addr = 9'd0; cpu_wdata = 0; cpu_req = 1;
    ldr_rw = 0; ldr_size = 0; ldr_addr = 9'd100; ldr_wdata = 32'h0000005A; ldr_req = 1;
    c_done = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) chk("t2_grant_cpu", 64'(grant), 64'h2);
      if (cpu_mfc) begin
        c_done = c;
        break;
      end
    end
    chk("t2_cpu_lat", 64'(c_done), 64'd6);
    chk("t2_cpu_rdata", 64'(cpu_rdata), 64'hCAFEF00D);
    cpu_req = 0;
    tick();
    chk("t2_idle_gap", 64'({grant, busy}), 64'h0);
    tick();
    chk("t2_grant_ldr", 64'(grant), 64'h1);
    tick();
    chk("t2_ldr_mfc", 64'(ldr_mfc), 64'h1);
    ldr_req = 0;
    tick();
    chk("t2_mem100", 64'(mem[100]), 64'h5A);
    chk("t2_ldr_rdata_hold", 64'(ldr_rdata), 64'hE3A01005);

    // Unaligned word read and top-of-memory byte accesses
    xact(1'b0, 1'b0, 1'b1, 9'h1FC, 32'h01020304, lat, beats, a_first, a_last, we_seen);
    xact(1'b1, 1'b1, 1'b1, 9'h1FE, 32'h0, lat, beats, a_first, a_last, we_seen);
    chk("t3_wrd_lat", 64'(lat), 64'd6);
    chk("t3_wrd_addr", {39'h0, a_first, 7'h0, a_last}, {39'h0, 9'h1FC, 7'h0, 9'h1FF});
    chk("t3_wrd_data", 64'(cpu_rdata), 64'h01020304);
    xact(1'b1, 1'b0, 1'b0, 9'h1FF, 32'hAABBCC77, lat, beats, a_first, a_last, we_seen);
    chk("t3_bwr_lat", 64'(lat), 64'd2);
    chk("t3_bwr_addr", {39'h0, a_first, 7'h0, a_last}, {39'h0, 9'h1FF, 7'h0, 9'h1FF});
    xact(1'b1, 1'b1, 1'b0, 9'h1FF, 32'h0, lat, beats, a_first, a_last, we_seen);
    chk("t3_brd_lat", 64'(lat), 64'd3);
    chk("t3_brd_beats", 64'(beats), 64'd1);
    chk("t3_brd_data", 64'(cpu_rdata), 64'h00000077);
    chk("t3_mem0_intact", 64'(mem[0]), 64'hCA);

    // Reset during a word write
    ldr_rw = 0; ldr_size = 1; ldr_addr = 9'd16; ldr_wdata = 32'h11223344; ldr_req = 1;
    tick();
    chk("t4_beat0", 64'({ram_en, ram_we, ram_addr}), 64'({1'b1, 1'b1, 9'd16}));
    tick();
    reset = 1'b1;
    tick();
    chk("t4_ctrl_zero", 64'({ram_en, ram_we, ram_addr, ram_wdata, cpu_mfc, ldr_mfc, grant, busy}), 64'h0);
    chk("t4_rdata_zero", {cpu_rdata, ldr_rdata}, 64'h0);
    reset = 1'b0;
    ldr_req = 0;
    tick();
    chk("t4_mem", 64'({mem[16], mem[17], mem[18], mem[19]}), 64'h11220000);
    chk("t4_no_mfc", 64'({cpu_mfc, ldr_mfc, busy}), 64'h0);

    // Round-robin with both sides streaming byte reads
    cpu_rw = 1; cpu_size = 0; cpu_addr = 9'h1FF; cpu_req = 1;
    ldr_rw = 1; ldr_size = 0; ldr_addr = 9'd100; ldr_req = 1;
    cpu_cnt = 0; ldr_cnt = 0; n_mfc = 0; bad_gap = 0; prev_c = 0; order = 8'h0;
    we_seen = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (ram_we) we_seen = 1'b1;
      if (cpu_mfc || ldr_mfc) begin
        if (c - prev_c != ((n_mfc == 0) ? 3 : 4)) bad_gap++;
        prev_c = c;
        order = {order[6:0], cpu_mfc};
        n_mfc++;
        chk("t5_grant_owner", 64'(grant), cpu_mfc ? 64'h2 : 64'h1);
        if (cpu_mfc) begin
          cpu_cnt++;
          if (cpu_cnt == 4) cpu_req = 0;
        end else begin
          ldr_cnt++;
          if (ldr_cnt == 4) ldr_req = 0;
        end
      end
      if (n_mfc == 8) break;
    end
    chk("t5_count", 64'(n_mfc), 64'd8);
    chk("t5_order", 64'(order), 64'hAA);
    chk("t5_gaps", 64'(bad_gap), 64'd0);
    chk("t5_no_we", 64'(we_seen), 64'd0);
    chk("t5_rdata", {cpu_rdata, ldr_rdata}, {32'h00000077, 32'h0000005A});
    cpu_req = 0;
    ldr_req = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
